cp0_reg: RTL and testbench

- Coprocessor-0 register file: Count, Compare, Status, Cause, EPC, PRId, Config.
- Sits upstream of the pipeline controller.
- Consumes the MEM-stage exception type and faulting-instruction info; records exception state.
- Supplies EPC, for eret redirection, plus Status/Cause, for interrupt qualification, back to the pipeline.
- Also generates the timer interrupt from Count/Compare.

---
 rtl/cp0_reg.sv | 176 +++++++++++++++++
 tb/tb_cp0_reg.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_reg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_reg
// Description : Coprocessor-0 register file (Count, Compare, Status, Cause,
//               EPC, PRId, Config). Records committed MEM-stage exceptions,
//               supplies EPC/Status/Cause to the pipeline controller and
//               raises the Count/Compare timer interrupt.
// Ports       : clk, rst (async, active-low)
//               we_i/waddr_i/data_i        - mtc0 write port
//               raddr_i -> data_o          - mfc0 combinational read port
//               int_i                      - hardware interrupt lines IP7..2
//               excepttype_i, current_inst_addr_i, is_in_delayslot_i
//                                          - committed exception info
//               count_o..prid_o            - current register contents
//               timer_int_o                - sticky timer interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
    parameter logic [31:0] CONFIG_RESET = 32'h00008000,
    parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam logic [4:0] c_reg_count   = 5'd9;
    localparam logic [4:0] c_reg_compare = 5'd11;
    localparam logic [4:0] c_reg_status  = 5'd12;
    localparam logic [4:0] c_reg_cause   = 5'd13;
    localparam logic [4:0] c_reg_epc     = 5'd14;
    localparam logic [4:0] c_reg_prid    = 5'd15;
    localparam logic [4:0] c_reg_config  = 5'd16;

    localparam logic [31:0] c_exc_eret   = 32'h0000000e;

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic        r_timer_int;

    logic        w_exc_hit;
    logic [4:0]  w_exc_code;
    logic        w_eret;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic [31:0] w_epc_next;

    // Map the committed exception type onto its ExcCode; unknown nonzero
    // types are not recognised and leave the registers alone.
    always_comb begin
        w_exc_hit  = 1'b1;
        w_exc_code = 5'd0;
        case (excepttype_i)
            32'h00000001: w_exc_code = 5'd0;
            32'h00000008: w_exc_code = 5'd8;
            32'h0000000a: w_exc_code = 5'd10;
            32'h0000000d: w_exc_code = 5'd13;
            32'h0000000c: w_exc_code = 5'd12;
            default:      w_exc_hit  = 1'b0;
        endcase
    end

    assign w_eret       = (excepttype_i == c_exc_eret);
    assign w_wr_count   = we_i && (waddr_i == c_reg_count);
    assign w_wr_compare = we_i && (waddr_i == c_reg_compare);
    assign w_wr_status  = we_i && (waddr_i == c_reg_status);
    assign w_wr_cause   = we_i && (waddr_i == c_reg_cause);
    assign w_wr_epc     = we_i && (waddr_i == c_reg_epc);

    // A delay-slot instruction restarts at its branch, one word earlier.
    assign w_epc_next = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                          : current_inst_addr_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= 32'd0;
            r_compare   <= 32'd0;
            r_status    <= STATUS_RESET;
            r_cause     <= 32'd0;
            r_epc       <= 32'd0;
            r_timer_int <= 1'b0;
        end else begin
            r_count <= w_wr_count ? data_i : (r_count + 32'd1);

            if (w_wr_compare) begin
                r_compare <= data_i;
            end

            // Sticky request: only an mtc0 to Compare acknowledges it, and the
            // acknowledge takes precedence over a match on the same edge.
            if (w_wr_compare) begin
                r_timer_int <= 1'b0;
            end else if ((r_compare != 32'd0) && (r_count == r_compare)) begin
                r_timer_int <= 1'b1;
            end

            // Exception/eret own Status on their edge; the mtc0 is dropped.
            if (w_exc_hit) begin
                r_status[1] <= 1'b1;
            end else if (w_eret) begin
                r_status[1] <= 1'b0;
            end else if (w_wr_status) begin
                r_status <= data_i;
            end

            // Nested exceptions (EXL already set) keep the original EPC/BD.
            if (w_exc_hit) begin
                if (!r_status[1]) begin
                    r_epc <= w_epc_next;
                end
            end else if (w_wr_epc) begin
                r_epc <= data_i;
            end

            r_cause[15:10] <= int_i;
            if (w_exc_hit) begin
                if (!r_status[1]) begin
                    r_cause[31] <= is_in_delayslot_i;
                end
                r_cause[6:2] <= w_exc_code;
            end else if (w_wr_cause) begin
                r_cause[23:22] <= data_i[23:22];
                r_cause[9:8]   <= data_i[9:8];
            end
        end
    end

    // Read port shows pre-write state; the pipeline forwards pending mtc0s.
    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            c_reg_count:   data_o = r_count;
            c_reg_compare: data_o = r_compare;
            c_reg_status:  data_o = r_status;
            c_reg_cause:   data_o = r_cause;
            c_reg_epc:     data_o = r_epc;
            c_reg_prid:    data_o = PRID_VALUE;
            c_reg_config:  data_o = CONFIG_RESET;
            default:       data_o = 32'd0;
        endcase
    end

    assign count_o     = r_count;
    assign compare_o   = r_compare;
    assign status_o    = r_status;
    assign cause_o     = r_cause;
    assign epc_o       = r_epc;
    assign config_o    = CONFIG_RESET;
    assign prid_o      = PRID_VALUE;
    assign timer_int_o = r_timer_int;

endmodule
`default_nettype wire

// File: tb/tb_cp0_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_reg
// Description : Self-checking bench for cp0_reg. A register-array model keyed
//               by CP0 register number is advanced on every rising edge and
//               compared against all DUT outputs; directed scenarios pin the
//               model with literal values, then randomized traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_reg;

    localparam logic [31:0] PRID_VALUE   = 32'h004c0102;
    localparam logic [31:0] CONFIG_RESET = 32'h00008000;
    localparam logic [31:0] STATUS_RESET = 32'h10000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o;
    logic [31:0] config_o, prid_o;
    logic        timer_int_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cp0_reg #(
        .PRID_VALUE   (PRID_VALUE),
        .CONFIG_RESET (CONFIG_RESET),
        .STATUS_RESET (STATUS_RESET)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .raddr_i             (raddr_i),
        .data_i              (data_i),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .data_o              (data_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .config_o            (config_o),
        .prid_o              (prid_o),
        .timer_int_o         (timer_int_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: registers indexed by number -------
    logic [31:0] m  [0:31];
    logic [31:0] mo [0:31];
    logic        m_t;

    function automatic bit mapped(input logic [4:0] n);
        return (n == 9) || (n == 11) || (n == 12) || (n == 13) ||
               (n == 14) || (n == 15) || (n == 16);
    endfunction

    function automatic logic [31:0] wmask(input logic [4:0] n);
        case (n)
            5'd9, 5'd11, 5'd12, 5'd14: return 32'hFFFFFFFF;
            5'd13:                     return 32'h00C00300;
            default:                   return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        m[12] = STATUS_RESET;
        m[15] = PRID_VALUE;
        m[16] = CONFIG_RESET;
        m_t   = 1'b0;
    endtask

    task automatic model_step();
        int  code;
        bit  rec, er, blocked;
        for (int i = 0; i < 32; i++) mo[i] = m[i];
        case (excepttype_i)
            32'h1:   code = 0;
            32'h8:   code = 8;
            32'ha:   code = 10;
            32'hd:   code = 13;
            32'hc:   code = 12;
            default: code = -1;
        endcase
        rec = (code >= 0);
        er  = (excepttype_i == 32'he);
        if (we_i) begin
            blocked = (rec && (waddr_i inside {5'd12, 5'd13, 5'd14})) ||
                      (er && waddr_i == 5'd12);
            if (!blocked)
                m[waddr_i] = (mo[waddr_i] & ~wmask(waddr_i)) | (data_i & wmask(waddr_i));
        end
        if (!(we_i && waddr_i == 5'd9)) m[9] = mo[9] + 32'd1;
        if (we_i && waddr_i == 5'd11)           m_t = 1'b0;
        else if (mo[11] != 0 && mo[9] == mo[11]) m_t = 1'b1;
        if (rec) begin
            if (!mo[12][1]) begin
                m[14]     = current_inst_addr_i - (is_in_delayslot_i ? 32'd4 : 32'd0);
                m[13][31] = is_in_delayslot_i;
            end
            m[12][1]   = 1'b1;
            m[13][6:2] = code[4:0];
        end
        if (er) m[12][1] = 1'b0;
        m[13][15:10] = int_i;
    endtask

    // Single compare process: advance the model on the edge, check after it.
    always @(posedge clk) begin
        if (!rst) model_reset();
        else      model_step();
        #1;
        chk("count_o",     count_o,     m[9]);
        chk("compare_o",   compare_o,   m[11]);
        chk("status_o",    status_o,    m[12]);
        chk("cause_o",     cause_o,     m[13]);
        chk("epc_o",       epc_o,       m[14]);
        chk("prid_o",      prid_o,      m[15]);
        chk("config_o",    config_o,    m[16]);
        chk("timer_int_o", {31'b0, timer_int_o}, {31'b0, m_t});
        chk("data_o",      data_o,      mapped(raddr_i) ? m[raddr_i] : 32'h0);
    end

    // ---------------- stimulus ---------------------------------------------
    initial begin
        int r;
        rst = 1'b0; we_i = 1'b0; waddr_i = '0; raddr_i = 5'd3; data_i = '0;
        int_i = '0; excepttype_i = '0; current_inst_addr_i = '0; is_in_delayslot_i = 1'b0;

        @(negedge clk);
        chk("rst_count",   count_o,   32'h0);
        chk("rst_compare", compare_o, 32'h0);
        chk("rst_status",  status_o,  32'h10000000);
        chk("rst_cause",   cause_o,   32'h0);
        chk("rst_epc",     epc_o,     32'h0);
        chk("rst_config",  config_o,  32'h00008000);
        chk("rst_prid",    prid_o,    32'h004c0102);
        chk("rst_timer",   {31'b0, timer_int_o}, 32'h0);
        chk("rd_unmapped", data_o,    32'h0);

        @(negedge clk);
        rst = 1'b1; raddr_i = 5'd12;
        #1 chk("rd_status", data_o, 32'h10000000);
        chk("count_start", count_o, 32'h0);
        @(negedge clk);
        chk("count_inc1", count_o, 32'h1);
        raddr_i = 5'd16; #1 chk("rd_config", data_o, 32'h00008000);
        raddr_i = 5'd15; #1 chk("rd_prid",   data_o, 32'h004c0102);
        raddr_i = 5'd9;  #1 chk("rd_count",  data_o, 32'h1);
        @(negedge clk);
        chk("count_inc2", count_o, 32'h2);

        // Timer: Count=0x10, then Compare=0x20
        we_i = 1'b1; waddr_i = 5'd9; data_i = 32'h10;
        @(negedge clk);
        chk("count_load", count_o, 32'h10);
        waddr_i = 5'd11; data_i = 32'h20;
        @(negedge clk);
        we_i = 1'b0;
        chk("compare_load", compare_o, 32'h20);
        for (int i = 0; i < 64 && count_o != 32'h20; i++) @(negedge clk);
        chk("count_reach_20", count_o, 32'h20);
        chk("timer_before", {31'b0, timer_int_o}, 32'h0);
        @(negedge clk);
        chk("timer_rise", {31'b0, timer_int_o}, 32'h1);
        repeat (3) @(negedge clk);
        chk("timer_hold", {31'b0, timer_int_o}, 32'h1);
        we_i = 1'b1; waddr_i = 5'd11; data_i = 32'h40;
        @(negedge clk);
        we_i = 1'b0;
        chk("timer_clear", {31'b0, timer_int_o}, 32'h0);

        // Count wrap
        we_i = 1'b1; waddr_i = 5'd9; data_i = 32'hFFFFFFFE;
        @(negedge clk);
        we_i = 1'b0;
        chk("wrap_a", count_o, 32'hFFFFFFFE);
        @(negedge clk);
        chk("wrap_b", count_o, 32'hFFFFFFFF);
        @(negedge clk);
        chk("wrap_c", count_o, 32'h0);

        // syscall, not in delay slot
        excepttype_i = 32'h8; current_inst_addr_i = 32'h100; is_in_delayslot_i = 1'b0;
        @(negedge clk);
        excepttype_i = 32'h0;
        chk("sys_epc",  epc_o, 32'h100);
        chk("sys_code", {27'b0, cause_o[6:2]}, 32'd8);
        chk("sys_exl",  {31'b0, status_o[1]}, 32'h1);
        chk("sys_bd",   {31'b0, cause_o[31]}, 32'h0);
        excepttype_i = 32'he;
        @(negedge clk);
        excepttype_i = 32'h0;
        chk("eret_exl0", {31'b0, status_o[1]}, 32'h0);

        // syscall in delay slot
        excepttype_i = 32'h8; current_inst_addr_i = 32'h200; is_in_delayslot_i = 1'b1;
        @(negedge clk);
        excepttype_i = 32'h0; is_in_delayslot_i = 1'b0;
        chk("ds_epc", epc_o, 32'h1FC);
        chk("ds_bd",  {31'b0, cause_o[31]}, 32'h1);

        // overflow while EXL=1
        excepttype_i = 32'hc; current_inst_addr_i = 32'h300;
        @(negedge clk);
        excepttype_i = 32'h0;
        chk("nest_epc",  epc_o, 32'h1FC);
        chk("nest_code", {27'b0, cause_o[6:2]}, 32'd12);
        excepttype_i = 32'he;
        @(negedge clk);
        excepttype_i = 32'h0;
        chk("eret2_exl", {31'b0, status_o[1]}, 32'h0);
        chk("eret2_epc", epc_o, 32'h1FC);

        // exception beats same-cycle mtc0 EPC
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'hDEAD;
        excepttype_i = 32'ha; current_inst_addr_i = 32'h400;
        @(negedge clk);
        we_i = 1'b0; excepttype_i = 32'h0;
        chk("race_epc",  epc_o, 32'h400);
        chk("race_code", {27'b0, cause_o[6:2]}, 32'd10);

        int_i = 6'b100001;
        @(negedge clk);
        chk("cause_ip", {26'b0, cause_o[15:10]}, 32'h21);
        chk("cause_pre", cause_o, 32'h00008428);
        we_i = 1'b1; waddr_i = 5'd13; data_i = 32'hFFFFFFFF;
        @(negedge clk);
        we_i = 1'b0;
        chk("cause_wmask", cause_o, 32'h00C08728);

        // randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            we_i = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            case (r)
                0: waddr_i = 5'd9;   1: waddr_i = 5'd11; 2: waddr_i = 5'd12;
                3: waddr_i = 5'd13;  4: waddr_i = 5'd14; 5: waddr_i = 5'd15;
                6: waddr_i = 5'd16;  default: waddr_i = 5'($urandom);
            endcase
            data_i = $urandom;
            if (waddr_i == 5'd9 && $urandom_range(0, 3) != 0) we_i = 1'b0;
            if (waddr_i == 5'd11 && $urandom_range(0, 1) == 1)
                data_i = m[9] + 32'($urandom_range(2, 6));
            r = $urandom_range(0, 15);
            case (r)
                9:  excepttype_i = 32'h1;  10: excepttype_i = 32'h8;
                11: excepttype_i = 32'ha;  12: excepttype_i = 32'hd;
                13: excepttype_i = 32'hc;  14: excepttype_i = 32'he;
                15: excepttype_i = $urandom;
                default: excepttype_i = 32'h0;
            endcase
            current_inst_addr_i = $urandom;
            is_in_delayslot_i   = 1'($urandom);
            int_i               = 6'($urandom);
            raddr_i             = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(9, 16)) : 5'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #3 rst = 1'b0;
                #1;
                chk("async_rst_count",  count_o,  32'h0);
                chk("async_rst_status", status_o, 32'h10000000);
                chk("async_rst_epc",    epc_o,    32'h0);
                chk("async_rst_timer",  {31'b0, timer_int_o}, 32'h0);
                @(negedge clk);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        we_i = 1'b0; excepttype_i = 32'h0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
